// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank: AXI4-Lite slave with NUM_CTRL RW and NUM_STAT RO regs.
// Optional build macro AXI_LITE_DECERR_EN: SLVERR/DECERR error responses.
module axi_lite_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_CTRL = 4,
  parameter int NUM_STAT = 2,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] CTRL_RST_VAL = '0,
  localparam int DW = C_S_AXI_DATA_WIDTH,
  localparam int AW = C_S_AXI_ADDR_WIDTH,
  localparam int SB = DW / 8,
  localparam int SN = (NUM_STAT > 0) ? NUM_STAT : 1
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic [AW-1:0]         s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DW-1:0]         s_axi_wdata,
  input  logic [SB-1:0]         s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [AW-1:0]         s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DW-1:0]         s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [NUM_CTRL*DW-1:0] ctrl_regs,
  output logic [NUM_CTRL-1:0]   ctrl_wr_pulse,
  input  logic [SN*DW-1:0]      stat_regs,
  output logic                  data_en
);

  localparam int ADDR_LSB = (DW == 64) ? 3 : 2;
  localparam int IW = AW - ADDR_LSB;

  logic          ready_en;
  logic          aw_held;
  logic          w_held;
  logic [IW-1:0] aw_idx;
  logic [IW-1:0] ar_idx;
  logic [DW-1:0] w_data;
  logic [SB-1:0] w_strb;
  logic [DW-1:0] ctrl_q [NUM_CTRL];
  logic [DW-1:0] rd_data;
  logic [1:0]    wr_rsp;
  logic [1:0]    rd_rsp;
  logic          aw_hs;
  logic          w_hs;
  logic          ar_hs;
  logic          commit;
  logic          unused_ok;

  // readies are held low until the first edge after reset release
  assign s_axi_awready = ready_en & ~aw_held & ~s_axi_bvalid;
  assign s_axi_wready  = ready_en & ~w_held & ~s_axi_bvalid;
  assign s_axi_arready = ready_en & ~s_axi_rvalid;

  assign aw_hs  = s_axi_awvalid & s_axi_awready;
  assign w_hs   = s_axi_wvalid & s_axi_wready;
  assign ar_hs  = s_axi_arvalid & s_axi_arready;
  assign commit = aw_held & w_held;
  assign ar_idx = s_axi_araddr[AW-1:ADDR_LSB];

  assign data_en = ctrl_q[0][0];

  assign unused_ok = ^{s_axi_awprot, s_axi_arprot,
                       s_axi_awaddr[ADDR_LSB-1:0],
                       s_axi_araddr[ADDR_LSB-1:0], stat_regs};

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_flat
    assign ctrl_regs[g*DW +: DW] = ctrl_q[g];
  end

`ifdef AXI_LITE_DECERR_EN
  logic wr_ctrl;
  logic wr_map;
  logic rd_map;
  assign wr_ctrl = int'(aw_idx) < NUM_CTRL;
  assign wr_map  = int'(aw_idx) < NUM_CTRL + NUM_STAT;
  assign rd_map  = int'(ar_idx) < NUM_CTRL + NUM_STAT;

  // error responses: status writes are slave errors, unmapped is decode error
  always_comb begin
    wr_rsp = 2'b00;
    rd_rsp = 2'b00;
    if (!wr_map) begin
      wr_rsp = 2'b11;
    end else if (!wr_ctrl) begin
      wr_rsp = 2'b10;
    end
    if (!rd_map) begin
      rd_rsp = 2'b11;
    end
  end
`else
  // every access completes OKAY
  always_comb begin
    wr_rsp = 2'b00;
    rd_rsp = 2'b00;
  end
`endif

  // read mux: ctrl regs, then status inputs, zero elsewhere
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (int'(ar_idx) == i) begin
        rd_data = ctrl_q[i];
      end
    end
    for (int i = 0; i < NUM_STAT; i++) begin
      if (int'(ar_idx) == NUM_CTRL + i) begin
        rd_data = stat_regs[i*DW +: DW];
      end
    end
  end

  // write channel: independent AW/W capture, commit when both held
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      ready_en     <= 1'b0;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= 2'b00;
    end else begin
      ready_en <= 1'b1;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axi_awaddr[AW-1:ADDR_LSB];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
      if (commit) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_rsp;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  // control registers: byte-lane update and one-cycle strobe on commit
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        ctrl_q[i] <= CTRL_RST_VAL;
      end
      ctrl_wr_pulse <= '0;
    end else begin
      ctrl_wr_pulse <= '0;
      if (commit) begin
        for (int i = 0; i < NUM_CTRL; i++) begin
          if (int'(aw_idx) == i) begin
            for (int b = 0; b < SB; b++) begin
              if (w_strb[b]) begin
                ctrl_q[i][8*b +: 8] <= w_data[8*b +: 8];
              end
            end
            ctrl_wr_pulse[i] <= 1'b1;
          end
        end
      end
    end
  end

  // read channel: data registered on the AR handshake edge
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= 2'b00;
    end else begin
      if (ar_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data;
        s_axi_rresp  <= rd_rsp;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule
